// File: rtl/regfile_32x64.sv
// 32 x DATA_W register file: X0-X30 writable, X31 hard-wired zero, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle WriteData to a read port addressing the written register.
module regfile_32x64 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NUM_REGS = 32;
  localparam int NUM_WR   = NUM_REGS - 1;

  // One-hot write enables; code 31 has no destination so it never enables anything.
  function automatic logic [NUM_WR-1:0] wr_decode(input logic we, input logic [4:0] addr);
    logic [NUM_WR-1:0] dec;
    dec = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we && (addr == 5'(i))) begin
        dec[i] = 1'b1;
      end else begin
        dec[i] = 1'b0;
      end
    end
    return dec;
  endfunction

  function automatic logic mux16(input logic [15:0] d, input logic [3:0] s);
    return d[s];
  endfunction

  logic [DATA_W-1:0] r_regs [0:NUM_WR-1];
  logic [DATA_W-1:0] w_bank [0:NUM_REGS-1];
  logic [NUM_WR-1:0] w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wr_en = wr_decode(RegWrite, WriteRegister);

  // Register array: synchronous active-low clear wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (!reset) begin
        r_regs[i] <= '0;
      end else if (w_wr_en[i]) begin
        r_regs[i] <= WriteData;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  for (genvar r = 0; r < NUM_WR; r++) begin : g_bank
    assign w_bank[r] = r_regs[r];
  end
  assign w_bank[NUM_REGS-1] = '0;

  // Per-bit select tree: two 16:1 units on addr[3:0], then addr[4] picks the half.
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [15:0] w_lo_col;
    logic [15:0] w_hi_col;
    for (genvar r = 0; r < 16; r++) begin : g_col
      assign w_lo_col[r] = w_bank[r][b];
      assign w_hi_col[r] = w_bank[r+16][b];
    end
    assign w_rd1[b] = ReadRegister1[4] ? mux16(w_hi_col, ReadRegister1[3:0])
                                       : mux16(w_lo_col, ReadRegister1[3:0]);
    assign w_rd2[b] = ReadRegister2[4] ? mux16(w_hi_col, ReadRegister2[3:0])
                                       : mux16(w_lo_col, ReadRegister2[3:0]);
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = RegWrite && reset && (ReadRegister1 == WriteRegister) && (ReadRegister1 != 5'd31);
  assign w_byp2 = RegWrite && reset && (ReadRegister2 == WriteRegister) && (ReadRegister2 != 5'd31);

  assign ReadData1 = w_byp1 ? WriteData : w_rd1;
  assign ReadData2 = w_byp2 ? WriteData : w_rd2;
`else
  assign ReadData1 = w_rd1;
  assign ReadData2 = w_rd2;
`endif

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 The parameter list SHALL be:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, register count; fixed, not overridable.

REQ-002 The port list SHALL be:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- RegWrite  input  1  write enable, sampled at rising edge of clk.
- WriteRegister  input  5  write address.
- WriteData  input  DATA_W  write data.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- ReadData1  output  DATA_W  read port 1 data.
- ReadData2  output  DATA_W  read port 2 data.

REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 The block SHALL hold 31 writable registers X0-X30, each DATA_W flip-flops updated only at the rising edge of clk.
REQ-005 X31 SHALL be hard-wired zero: reads return 0; writes to address 31 are discarded.
REQ-006 A write SHALL occur at a rising edge when reset==1 and RegWrite==1; only register WriteRegister is loaded with WriteData.
REQ-007 A 5:32 enable decoder SHALL gate the write, so at most one register changes per cycle.
REQ-008 Reads SHALL be combinational, with zero-cycle latency from address or register change.
REQ-009 Each read port SHALL use a per-bit 32:1 select tree built from 16:1 mux units:
- address bits [3:0] select within each half;
- address bit [4] selects between the two halves.
REQ-010 Both read ports SHALL be independent; both addressing the same register SHALL return identical data.
REQ-011 With RegWrite==0, all registers SHALL hold their value indefinitely.
REQ-012 Without bypass, a read of the register being written SHALL return the old value until the edge and the new value after it.
REQ-013 Write address and read addresses SHALL be fully decoded; no X/Z SHALL propagate for any legal 5-bit address.

Reset
REQ-014 On a rising edge with reset==0, X0-X30 SHALL load 0 and RegWrite SHALL be ignored.
REQ-015 After reset, ReadData1 and ReadData2 SHALL read 0 for every address.
REQ-016 Reset asserted mid-sequence SHALL override any write in that same cycle.
REQ-017 Deasserting reset SHALL make the write of the next edge effective.
REQ-018 Reset SHALL have no asynchronous effect between edges.

Configuration
REQ-019 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-020 With REGFILE_BYPASS_EN defined, a port whose address equals WriteRegister while RegWrite==1, reset==1 and address!=31 SHALL output WriteData combinationally in the same cycle.
REQ-021 Without REGFILE_BYPASS_EN, REQ-012 behaviour SHALL apply and no bypass logic SHALL be synthesized.
REQ-022 Address 31 SHALL read 0 in both configurations.

Verification
REQ-023 Reset: hold reset=0 one edge after writing X5=64'hDEAD_BEEF; release, read port1=5 -> ReadData1=0.
REQ-024 Write/read all: write Xi=64'h0101_0101_0101_0100+i for i=0..30, then sweep both ports over 0..31 -> each returns its pattern; address 31 returns 0.
REQ-025 X31 discard: RegWrite=1, WriteRegister=31, WriteData=all ones -> ReadData1 at address 31 = 0; no other register changes.
REQ-026 Write gate: RegWrite=0, WriteRegister=7, WriteData=64'h1234 after X7=64'hAAAA -> X7 still 64'hAAAA.
REQ-027 Same-cycle read/write on X3 (old 1, new 2):
- without macro, ReadData2=1 before the edge and 2 after;
- with REGFILE_BYPASS_EN, ReadData2=2 before the edge.
REQ-028 Reset and write together: reset=0, RegWrite=1, X9=64'hFFFF at the same edge -> X9=0 afterwards.
